// File: rtl/gp_chunk_add_seq.sv
// Multi-cycle wide adder: processes one CHUNK-bit slice per cycle, LSB chunk first,
// using an external group generate/propagate prefix unit shared across all chunks.
module gp_chunk_add_seq #(
   parameter  int CHUNK  = 6,
   parameter  int NCHUNK = 4,
   localparam int W      = CHUNK * NCHUNK,
   localparam int IW     = $clog2(NCHUNK)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_a,
   input  logic [W-1:0]     in_b,
   input  logic             in_cin,
   output logic [CHUNK-1:0] gp_p,
   output logic [CHUNK-1:0] gp_g,
   input  logic [CHUNK-1:0] gp_P,
   input  logic [CHUNK-1:0] gp_G,
   output logic [IW-1:0]    chunk_idx,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_sum,
   output logic             out_cout,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic [W-1:0]     sum_q, sum_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             valid_q, valid_d;

   logic [CHUNK-1:0] a_chunk, b_chunk;
   logic [CHUNK-1:0] p_chunk, g_chunk;
   logic [CHUNK-1:0] carry_vec;
   logic [CHUNK-1:0] sum_chunk;
   logic             carry_out;
   logic             accept;
   int               lo;

   assign in_ready = (state_q == S_IDLE) & ~rst;
   assign accept   = in_valid & in_ready;
   assign lo       = int'(idx_q) * CHUNK;

   // Bit p/g toward the prefix unit are kept apart from the sum logic so the
   // combinational return path through gp_P/gp_G never loops back into itself.
   always_comb begin : chunk_pg
      a_chunk = a_q[lo +: CHUNK];
      b_chunk = b_q[lo +: CHUNK];
      p_chunk = a_chunk ^ b_chunk;
      g_chunk = a_chunk & b_chunk;
      gp_p    = '0;
      gp_g    = '0;
      if (state_q == S_RUN) begin
         gp_p = p_chunk;
         gp_g = g_chunk;
      end
   end

   always_comb begin : chunk_sum
      carry_vec[0] = carry_q;
      for (int k = 1; k < CHUNK; k++) begin
         carry_vec[k] = gp_G[k-1] | (gp_P[k-1] & carry_q);
      end
      sum_chunk = p_chunk ^ carry_vec;
      carry_out = gp_G[CHUNK-1] | (gp_P[CHUNK-1] & carry_q);
   end

   // NOTE: every _d gets its hold value first, so no path through the case leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin : next_state
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      valid_d = valid_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               a_d     = in_a;
               b_d     = in_b;
               carry_d = in_cin;
               idx_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            sum_d[lo +: CHUNK] = sum_chunk;
            carry_d            = carry_out;
            if (idx_q == IW'(NCHUNK - 1)) begin
               cout_d  = carry_out;
               valid_d = 1'b1;
               state_d = S_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               valid_d = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of every other flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         valid_q <= valid_d;
      end
   end

   // NOTE: operand registers carry no reset; they are always loaded before use,
   // and leaving them out of the reset keeps reset off their enable path.
   always_ff @(posedge clk) begin
      a_q <= a_d;
      b_q <= b_d;
   end

   assign chunk_idx = idx_q;
   assign out_valid = valid_q;
   assign out_sum   = sum_q;
   assign out_cout  = cout_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_gp_chunk_add_seq.sv
// Bench for gp_chunk_add_seq: models the external prefix unit and scoreboards
// every accepted operation against a plain integer add.
module tb_gp_chunk_add_seq;

   localparam int CHUNK  = 6;
   localparam int NCHUNK = 4;
   localparam int W      = CHUNK * NCHUNK;
   localparam int IW     = $clog2(NCHUNK);

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_a;
   logic [W-1:0]     in_b;
   logic             in_cin;
   logic [CHUNK-1:0] gp_p;
   logic [CHUNK-1:0] gp_g;
   logic [CHUNK-1:0] gp_P;
   logic [CHUNK-1:0] gp_G;
   logic [IW-1:0]    chunk_idx;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     out_sum;
   logic             out_cout;
   logic             busy;

   always #5 clk = ~clk;

   gp_chunk_add_seq #(.CHUNK(CHUNK), .NCHUNK(NCHUNK)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .gp_p      (gp_p),
      .gp_g      (gp_g),
      .gp_P      (gp_P),
      .gp_G      (gp_G),
      .chunk_idx (chunk_idx),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .busy      (busy)
   );

   // Prefix unit: bit k of P/G covers chunk bits 0..k.
   function automatic logic [2*CHUNK-1:0] prefix(input logic [CHUNK-1:0] p, input logic [CHUNK-1:0] g);
      logic [CHUNK-1:0] pp;
      logic [CHUNK-1:0] gg;
      pp[0] = p[0];
      gg[0] = g[0];
      for (int k = 1; k < CHUNK; k++) begin
         pp[k] = pp[k-1] & p[k];
         gg[k] = g[k] | (p[k] & gg[k-1]);
      end
      return {pp, gg};
   endfunction

   assign {gp_P, gp_G} = prefix(gp_p, gp_g);

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
   } res_t;

   res_t sb[$];
   res_t mon_r;
   logic [W:0] mon_full;
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor sampled on the falling edge, away from DUT updates.
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
      end else begin
         if (in_valid && in_ready) begin
            mon_full = {1'b0, in_a} + {1'b0, in_b} + {{W{1'b0}}, in_cin};
            sb.push_back('{sum: mon_full[W-1:0], cout: mon_full[W]});
         end
         if (out_valid && out_ready) begin
            check("sb_pending", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
               mon_r = sb.pop_front();
               check("sb_sum", 64'(out_sum), 64'(mon_r.sum));
               check("sb_cout", 64'(out_cout), 64'(mon_r.cout));
            end
         end
      end
   end

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input int hold);
      logic [W:0]   full;
      logic [W-1:0] px;
      logic [W-1:0] gx;
      int           n;
      full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      px   = a ^ b;
      gx   = a & b;
      in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1; out_ready = 1'b0;
      n = 0;
      while (!in_ready && n < 20) begin step(1); n++; end
      check("accept_ready", 64'(in_ready), 64'd1);
      check("idle_gp_p", 64'(gp_p), 64'd0);
      check("idle_gp_g", 64'(gp_g), 64'd0);
      step(1);
      in_valid = 1'b0;
      for (int i = 0; i < NCHUNK; i++) begin
         check("run_idx", 64'(chunk_idx), 64'(i));
         check("run_gp_p", 64'(gp_p), 64'(px[i*CHUNK +: CHUNK]));
         check("run_gp_g", 64'(gp_g), 64'(gx[i*CHUNK +: CHUNK]));
         check("run_no_valid", 64'(out_valid), 64'd0);
         check("run_busy", 64'(busy), 64'd1);
         step(1);
      end
      check("latency_valid", 64'(out_valid), 64'd1);
      check("done_gp_p", 64'(gp_p), 64'd0);
      check("done_gp_g", 64'(gp_g), 64'd0);
      check("done_sum", 64'(out_sum), 64'(full[W-1:0]));
      check("done_cout", 64'(out_cout), 64'(full[W]));
      in_valid = (hold > 0);
      in_a = ~a; in_b = b + 1'b1;
      for (int h = 0; h < hold; h++) begin
         check("bp_in_ready", 64'(in_ready), 64'd0);
         step(1);
         check("bp_valid", 64'(out_valid), 64'd1);
         check("bp_sum", 64'(out_sum), 64'(full[W-1:0]));
         check("bp_cout", 64'(out_cout), 64'(full[W]));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step(1);
      out_ready = 1'b0;
      check("release_valid", 64'(out_valid), 64'd0);
      check("release_busy", 64'(busy), 64'd0);
      check("release_ready", 64'(in_ready), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      rst = 1'b1; in_valid = 1'b1; in_a = 24'hABCDEF; in_b = 24'h123456; in_cin = 1'b1;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(1);
         check("rst_in_ready", 64'(in_ready), 64'd0);
         check("rst_valid", 64'(out_valid), 64'd0);
         check("rst_sum", 64'(out_sum), 64'd0);
         check("rst_busy", 64'(busy), 64'd0);
      end
      check("rst_idx", 64'(chunk_idx), 64'd0);
      check("rst_cout", 64'(out_cout), 64'd0);
      in_valid = 1'b0;
      rst      = 1'b0;
      #1;
      check("post_rst_ready", 64'(in_ready), 64'd1);

      run_op(24'hFFFFFF, 24'h000001, 1'b0, 0);
      run_op(24'h123456, 24'h654321, 1'b1, 3);

      // Reset in the middle of RUN discards the operation.
      in_a = 24'h0F0F0F; in_b = 24'h0F0F0F; in_cin = 1'b0; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin step(1); n++; end
      step(1);
      in_valid = 1'b0;
      step(2);
      check("mr_idx", 64'(chunk_idx), 64'd2);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      check("mr_busy", 64'(busy), 64'd0);
      check("mr_idx_clr", 64'(chunk_idx), 64'd0);
      check("mr_sum_clr", 64'(out_sum), 64'd0);
      for (int i = 0; i < NCHUNK + 1; i++) begin
         check("mr_no_valid", 64'(out_valid), 64'd0);
         step(1);
      end
      run_op(24'h000010, 24'h000020, 1'b0, 0);

      for (int i = 0; i < 4; i++) begin
         run_op(W'($urandom()), W'($urandom()), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
      end

      // Back-to-back with in_valid held high and out_ready always asserted.
      in_a = 24'h800000; in_b = 24'h800000; in_cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin step(1); n++; end
      check("b2b_ready0", 64'(in_ready), 64'd1);
      step(1);
      in_a = 24'h00003F; in_b = 24'h000001;
      n = 0;
      while (!in_ready && n < 20) begin step(1); n++; end
      check("b2b_spacing", 64'(n + 1), 64'd6);
      step(1);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin step(1); n++; end
      check("b2b_valid", 64'(out_valid), 64'd1);
      check("b2b_sum", 64'(out_sum), 64'h40);
      step(1);
      check("b2b_drop", 64'(out_valid), 64'd0);
      out_ready = 1'b0;
      step(2);
      check("sb_drained", 64'(sb.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
